// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with NOP-bubble ctrl, flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with a registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              acc, rel;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CTRL_W-1:0] ctrl_out;
    assign acc       = in_valid && in_ready;
    assign rel       = out_valid && out_ready;
    assign out_ctrl  = out_valid ? ctrl_out : '0;
    assign stall_cnt = stall_q;
    always_comb begin
        stall_d = (out_valid && !out_ready && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    end
    always_ff @(posedge clk) begin
        stall_q <= rst ? '0 : stall_d;
    end
`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    assign in_ready  = in_ready_q && !rst;
    assign out_valid = state_q != EMPTY;
    assign out_data  = main_data_q;
    assign ctrl_out  = main_ctrl_q;
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ONE: begin
                if (acc && rel) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (acc) begin
                    state_d     = FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (rel) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a release can happen
                if (rel) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end
        in_ready_d = state_d != FULL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end
`else
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    assign in_ready  = rst || !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign ctrl_out  = ctrl_q;
    always_comb begin
        valid_d = flush ? 1'b0 : acc ? 1'b1 : rel ? 1'b0 : valid_q;
        data_d  = flush ? '0 : acc ? in_data : data_q;
        ctrl_d  = flush ? '0 : acc ? in_ctrl : ctrl_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus random traffic against a queue-based model of the stage.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;
    int checks = 0;
    int failures = 0;
    logic [CW+DW-1:0] mq[$];
    int m_stall = 0;
    bit m_rdy;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit mdl_ready();
        return rst ? !SKID : (SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready));
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else begin
            m_rdy = mdl_ready();
            if (mq.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
            if (flush) mq.delete();
            else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && m_rdy) mq.push_back({in_ctrl, in_data});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== !SKID) begin failures++; $display("FAIL rst_in_ready got=%b exp=%b", in_ready, !SKID); end
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL rst_out_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data = 32'h1234; in_ctrl = 16'h00A5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h1234) begin failures++; $display("FAIL basic_data got=%h exp=1234", out_data); end
        checks++; if (out_ctrl !== 16'h00A5) begin failures++; $display("FAIL basic_ctrl got=%h exp=00a5", out_ctrl); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL basic_bubble_ctrl got=%h exp=0", out_ctrl); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin failures++; $display("FAIL stream_beat%0d got=%b/%h exp=1/%h", i, out_valid, out_data, i); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAA; in_ctrl = 16'h3;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_data !== 32'hAAA || out_ctrl !== 16'h3) begin failures++; $display("FAIL hold_stable%0d got=%h/%h exp=aaa/3", k, out_data, out_ctrl); end
        end
        checks++; if (stall_cnt !== 4'd5) begin failures++; $display("FAIL hold_stall got=%0d exp=5", stall_cnt); end
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_skid_room got=%b exp=1", in_ready); end
        in_valid = 1'b1; in_data = 32'hBBB; in_ctrl = 16'h4;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_full_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== 32'hAAA) begin failures++; $display("FAIL hold_full_data got=%h exp=aaa", out_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hBBB) begin failures++; $display("FAIL hold_skid_out got=%b/%h exp=1/bbb", out_valid, out_data); end
        tick();
`else
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        tick();
`endif
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 16'h1;
        tick();
        in_data = 32'h22; in_ctrl = 16'h2;
        tick();
        flush = 1'b1; in_data = 32'h99; in_ctrl = 16'h9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL flush_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL flush_data got=%h exp=0", out_data); end
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data === 32'h99) begin failures++; $display("FAIL flush_ghost%0d got=%b/%h exp=0/not99", k, out_valid, out_data); end
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h7;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL sat_rst_stall got=%0d exp=0", stall_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_rst_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h5;
        tick();
        in_data = 32'h66; in_ctrl = 16'h6;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL midrst_ctrl got=%h exp=0", out_ctrl); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL midrst_ghost%0d got=%b/%h exp=0/0", k, out_valid, out_data); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            in_data   = $urandom;
            in_ctrl   = CW'($urandom);
            #1;
            checks++; if (in_ready !== mdl_ready()) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, mdl_ready()); end
            checks++; if (out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, out_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if ({out_ctrl, out_data} !== mq[0]) begin failures++; $display("FAIL rnd_beat cyc=%0d got=%h exp=%h", i, {out_ctrl, out_data}, mq[0]); end
            end else begin
                checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL rnd_bubble cyc=%0d got=%h exp=0", i, out_ctrl); end
            end
            checks++; if (stall_cnt !== NW'(m_stall)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_stall); end
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of the datapath payload (operands, immediates, PC).
REQ-002 SHALL provide parameter CTRL_W, default 16, width of the control payload (reg_write, mem_read, mem_write, branch, jump, ALU op, ...).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit: synchronous squash of all held entries.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: stage can accept a beat.
REQ-009 SHALL have port in_data, input, DATA_W bits: upstream datapath payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W bits: upstream control payload.
REQ-011 SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-013 SHALL have port out_data, output, DATA_W bits: held datapath payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W bits: held control payload.
REQ-015 SHALL have port stall_cnt, output, CNT_W bits: count of back-pressured cycles.

Function
REQ-016 SHALL accept a beat in a cycle where in_valid && in_ready, and SHALL release a beat in a cycle where out_valid && out_ready.
REQ-017 SHALL preserve order and SHALL never drop or duplicate a beat, except beats discarded by flush.
REQ-018 SHALL present an accepted beat on out_* one cycle after acceptance (latency 1) when the stage was empty.
REQ-019 SHALL drive out_ctrl to all-zeros whenever out_valid=0, so an empty stage reads downstream as a NOP bubble.
REQ-020 SHALL hold out_data and out_ctrl stable while out_valid && !out_ready.
REQ-021 On flush=1, SHALL at the next edge invalidate all entries and zero the stored data and ctrl; a beat offered in the same cycle SHALL be discarded.
REQ-022 SHALL give flush priority over simultaneous accept/release; a beat released downstream in the flush cycle still counts as delivered.
REQ-023 SHALL increment stall_cnt each cycle with out_valid && !out_ready, SHALL saturate at 2^CNT_W-1 (no wrap), and SHALL be unaffected by flush.
REQ-024 With both accept and release in one cycle on a one-entry occupancy, SHALL replace the entry with the new beat (throughput 1 beat/cycle).

Reset
REQ-025 On rst=1 at a clock edge, SHALL set out_valid=0, out_data=0, out_ctrl=0 and stall_cnt=0, and SHALL empty the skid entry; rst SHALL override flush and all handshakes.
REQ-026 During reset, in_ready SHALL be 0 with the skid buffer enabled, and 1 without it.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL select the buffering scheme.
REQ-028 Defined: two entries (main + skid), FSM EMPTY/ONE/FULL, in_ready registered as (state != FULL).
- EMPTY->ONE on accept.
- ONE->FULL on accept without release.
- ONE->EMPTY on release without accept.
- FULL->ONE on release, with the skid entry moving to main.
- Any state->EMPTY on flush.
REQ-029 Not defined: single entry; in_ready = !out_valid || out_ready (combinational); no skid storage.

Verification
REQ-030 Reset, then in_valid=1, in_data=0x1234, in_ctrl=0x00A5, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_ctrl=0x00A5.
REQ-031 Stream 0x1..0x8 back-to-back with out_ready=1 -> eight consecutive out beats 0x1..0x8, no gaps, stall_cnt=0.
REQ-032 Hold one beat with out_ready=0 for 5 cycles -> out_data stable, stall_cnt=5; (SKID_EN) a second beat is accepted, then in_ready=0.
REQ-033 Two beats held (SKID_EN), assert flush with in_valid=1 and in_data=0x99 -> next cycle out_valid=0, out_ctrl=0, 0x99 never appears at the output.
REQ-034 CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt stops at 15; rst=1 -> stall_cnt=0, out_valid=0.
REQ-035 rst=1 asserted mid-stream with two beats held -> next cycle empty, out_ctrl=0, and neither held beat is later emitted.
